// File: rtl/fsm_control_param.sv
// Link-layer control FSM: latches N FIFO thresholds at INIT, reports IDLE/ACTIVE, and captures sticky per-FIFO errors.
// Optional FSM_UMBRAL_CHECK_EN: rejects zero or all-ones threshold fields on INIT exit and reports them on cfg_error.
module fsm_control_param #(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 4,
  parameter int IDLE_HOLD = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init,
  input  logic [NUM_FIFOS*UMBRAL_W-1:0]   umbral_in,
  input  logic [NUM_FIFOS-1:0]            fifo_error,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  output logic [NUM_FIFOS*UMBRAL_W-1:0]   umbrales_out,
  output logic                            active_out,
  output logic                            idle_out,
  output logic [NUM_FIFOS-1:0]            error_out,
`ifdef FSM_UMBRAL_CHECK_EN
  output logic [NUM_FIFOS-1:0]            cfg_error,
`endif
  output logic [4:0]                      state_out
);

  localparam logic [4:0] ST_RESET  = 5'b00001;
  localparam logic [4:0] ST_INIT   = 5'b00010;
  localparam logic [4:0] ST_IDLE   = 5'b00100;
  localparam logic [4:0] ST_ACTIVE = 5'b01000;
  localparam logic [4:0] ST_ERROR  = 5'b10000;

  localparam logic [3:0] HOLD_LAST = 4'(IDLE_HOLD - 1);

  logic [4:0] state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       any_err, all_empty, cfg_bad;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;

`ifdef FSM_UMBRAL_CHECK_EN
  logic [NUM_FIFOS-1:0] bad_fields;

  always_comb begin
    bad_fields = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      bad_fields[i] = (umbral_in[i*UMBRAL_W +: UMBRAL_W] == '0) ||
                      (umbral_in[i*UMBRAL_W +: UMBRAL_W] == '1);
    end
  end

  assign cfg_bad = |bad_fields;
`else
  assign cfg_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = ST_RESET;
    case (state)
      ST_RESET:  state_nxt = ST_INIT;
      ST_INIT:   state_nxt = (any_err || cfg_bad) ? ST_ERROR : ST_IDLE;
      ST_IDLE: begin
        if (any_err)         state_nxt = ST_ERROR;
        else if (!all_empty) state_nxt = ST_ACTIVE;
        else                 state_nxt = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (any_err)                                state_nxt = ST_ERROR;
        else if (all_empty && hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
        else                                        state_nxt = ST_ACTIVE;
      end
      ST_ERROR:  state_nxt = ST_ERROR;
      default:   state_nxt = ST_RESET;
    endcase
    if (init) state_nxt = ST_INIT;
  end

  // Counter only advances on all-empty ACTIVE cycles that do not leave the state.
  always_comb begin
    hold_nxt = '0;
    if (state == ST_ACTIVE && !init && !any_err && all_empty && hold_cnt != HOLD_LAST)
      hold_nxt = hold_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_RESET;
      hold_cnt     <= '0;
      umbrales_out <= '0;
      error_out    <= '0;
`ifdef FSM_UMBRAL_CHECK_EN
      cfg_error    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (state == ST_INIT) umbrales_out <= umbral_in;
      if (init) begin
        error_out <= '0;
`ifdef FSM_UMBRAL_CHECK_EN
        cfg_error <= '0;
`endif
      end else begin
        if (state_nxt == ST_ERROR) error_out <= error_out | fifo_error;
`ifdef FSM_UMBRAL_CHECK_EN
        if (state == ST_INIT) cfg_error <= cfg_error | bad_fields;
`endif
      end
    end
  end

  assign state_out  = state;
  assign active_out = (state == ST_ACTIVE);
  assign idle_out   = (state == ST_IDLE);

endmodule

// File: tb/tb_fsm_control_param.sv
// Directed-vector bench for fsm_control_param (NUM_FIFOS=5, UMBRAL_W=4, IDLE_HOLD=2).
module tb_fsm_control_param;

  localparam int N = 5;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, init;
  logic [N*W-1:0] umbral_in, umbrales_out;
  logic [N-1:0] fifo_error, fifo_empty, error_out;
  logic         active_out, idle_out;
  logic [4:0]   state_out;
`ifdef FSM_UMBRAL_CHECK_EN
  logic [N-1:0] cfg_error;
`endif

  always #5 clk = ~clk;

  fsm_control_param #(.NUM_FIFOS(N), .UMBRAL_W(W), .IDLE_HOLD(2)) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .umbral_in(umbral_in),
    .fifo_error(fifo_error),
    .fifo_empty(fifo_empty),
    .umbrales_out(umbrales_out),
    .active_out(active_out),
    .idle_out(idle_out),
    .error_out(error_out),
`ifdef FSM_UMBRAL_CHECK_EN
    .cfg_error(cfg_error),
`endif
    .state_out(state_out)
  );

  typedef struct {
    logic           rst;
    logic           ini;
    logic [N*W-1:0] umb;
    logic [N-1:0]   err;
    logic [N-1:0]   emp;
    logic [4:0]     st;
    logic [N-1:0]   eo;
    logic [N*W-1:0] uo;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic r, input logic i, input logic [N*W-1:0] u,
                     input logic [N-1:0] e, input logic [N-1:0] m,
                     input logic [4:0] s, input logic [N-1:0] eo, input logic [N*W-1:0] uo);
    vec_t v;
    v.rst = r; v.ini = i; v.umb = u; v.err = e; v.emp = m;
    v.st = s; v.eo = eo; v.uo = uo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    reset = 1'b0; init = 1'b0; umbral_in = '0; fifo_error = '0; fifo_empty = '1;

    //   rst  ini  umb       err     emp       state     err_out   umb_out
    add(0, 0, 20'h00000, 5'h00, 5'h1F, 5'b00001, 5'h00, 20'h00000);
    add(0, 0, 20'h00000, 5'h00, 5'h1F, 5'b00001, 5'h00, 20'h00000);
    add(0, 0, 20'h00000, 5'h00, 5'h1F, 5'b00001, 5'h00, 20'h00000);
    add(1, 0, 20'h00000, 5'h00, 5'h1F, 5'b00010, 5'h00, 20'h00000);
    add(1, 1, 20'h12345, 5'h00, 5'h1F, 5'b00010, 5'h00, 20'h12345);
    add(1, 1, 20'h12345, 5'h00, 5'h1F, 5'b00010, 5'h00, 20'h12345);
    add(1, 0, 20'h12345, 5'h00, 5'h1F, 5'b00100, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1F, 5'b00100, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1F, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1F, 5'b00100, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1F, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1F, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h00, 5'h1B, 5'b01000, 5'h00, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h04, 5'h1B, 5'b10000, 5'h04, 20'h12345);
    add(1, 0, 20'h0ABCD, 5'h10, 5'h1B, 5'b10000, 5'h14, 20'h12345);
    add(1, 0, 20'h54321, 5'h00, 5'h1B, 5'b10000, 5'h14, 20'h12345);
    add(1, 0, 20'h54321, 5'h00, 5'h1F, 5'b10000, 5'h14, 20'h12345);
    add(1, 1, 20'h54321, 5'h00, 5'h1F, 5'b00010, 5'h00, 20'h12345);
    add(1, 0, 20'h54321, 5'h00, 5'h1F, 5'b00100, 5'h00, 20'h54321);
    add(1, 0, 20'h54321, 5'h03, 5'h1B, 5'b10000, 5'h03, 20'h54321);
    add(1, 0, 20'h54321, 5'h00, 5'h1F, 5'b10000, 5'h03, 20'h54321);
    add(0, 0, 20'h54321, 5'h00, 5'h1F, 5'b00001, 5'h00, 20'h00000);
    add(0, 1, 20'h54321, 5'h00, 5'h1F, 5'b00001, 5'h00, 20'h00000);

    for (int k = 0; k < vecs.size(); k++) begin
      reset      = vecs[k].rst;
      init       = vecs[k].ini;
      umbral_in  = vecs[k].umb;
      fifo_error = vecs[k].err;
      fifo_empty = vecs[k].emp;
      step();
      chk($sformatf("v%0d_state", k), 32'(state_out), 32'(vecs[k].st));
      chk($sformatf("v%0d_error_out", k), 32'(error_out), 32'(vecs[k].eo));
      chk($sformatf("v%0d_umbrales", k), 32'(umbrales_out), 32'(vecs[k].uo));
      chk($sformatf("v%0d_active", k), 32'(active_out), 32'(vecs[k].st == 5'b01000));
      chk($sformatf("v%0d_idle", k), 32'(idle_out), 32'(vecs[k].st == 5'b00100));
`ifdef FSM_UMBRAL_CHECK_EN
      chk($sformatf("v%0d_cfg_error", k), 32'(cfg_error), 32'h0);
`endif
    end

    // Bounded wait for the ACTIVE -> IDLE debounce.
    reset = 1'b1; init = 1'b1; umbral_in = 20'h12345; fifo_error = '0; fifo_empty = '1;
    step();
    init = 1'b0;
    step();
    chk("seq_idle", 32'(state_out), 32'h04);
    fifo_empty = 5'h1B;
    step();
    chk("seq_active", 32'(state_out), 32'h08);
    fifo_empty = 5'h1F;
    n = 0;
    do begin
      step();
      n++;
    end while (!idle_out && n < 6);
    chk("seq_idle_hold_edges", 32'(n), 32'd2);

    // Reset mid-ACTIVE takes effect on the next edge.
    fifo_empty = 5'h1B;
    step();
    chk("seq_active_again", 32'(state_out), 32'h08);
    reset = 1'b0;
    step();
    chk("seq_midreset_state", 32'(state_out), 32'h01);
    chk("seq_midreset_active", 32'(active_out), 32'h0);

`ifdef FSM_UMBRAL_CHECK_EN
    reset = 1'b1; init = 1'b1; umbral_in = 20'h12F45; fifo_empty = '1;
    step();
    step();
    init = 1'b0;
    step();
    chk("cfg_state", 32'(state_out), 32'h10);
    chk("cfg_error_bits", 32'(cfg_error), 32'h04);
    chk("cfg_error_out", 32'(error_out), 32'h00);
    chk("cfg_umbrales", 32'(umbrales_out), 32'h12F45);
    init = 1'b1;
    step();
    chk("cfg_clear_state", 32'(state_out), 32'h02);
    chk("cfg_clear_bits", 32'(cfg_error), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
